// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns PC and IR, drives sync instruction-memory address, captures returned word.
// Latency: IR and PC update on the same edge as the fetch strobe; IM_addr is combinational (pc_next).
// Backpressure: none; strobes act immediately, every register holds when no strobe is asserted.
module instruction_fetch_unit #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              PC_clr,
    input  logic              PC_up,
    input  logic              IR_ld,
    input  logic [DATA_W-1:0] IM_rd_data,
    output logic [ADDR_W-1:0] IM_addr,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [3:0]        Opcode,
    output logic              IR_valid,
    output logic              PC_wrap,
    output logic [CNT_W-1:0]  Fetch_cnt
);

    logic [ADDR_W-1:0] pc_next;
    logic              pc_at_max;

    assign pc_at_max = (PC == {ADDR_W{1'b1}});

    always_comb begin
        pc_next = PC;
        if (PC_clr)
            pc_next = '0;
        else if (PC_up)
            pc_next = PC + ADDR_W'(1);
    end

    // Memory registers this address, so the word for PC arrives one cycle later.
    assign IM_addr = ResetN ? pc_next : '0;
    assign Opcode  = IR[DATA_W-1 -: 4];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            PC        <= '0;
            IR        <= '0;
            IR_valid  <= 1'b0;
            PC_wrap   <= 1'b0;
            Fetch_cnt <= '0;
        end else begin
            PC <= pc_next;
            if (PC_clr) begin
                IR        <= '0;
                IR_valid  <= 1'b0;
                PC_wrap   <= 1'b0;
                Fetch_cnt <= '0;
            end else begin
                if (IR_ld) begin
                    IR       <= IM_rd_data;
                    IR_valid <= 1'b1;
                    if (Fetch_cnt != {CNT_W{1'b1}})
                        Fetch_cnt <= Fetch_cnt + CNT_W'(1);
                end
                if (PC_up && pc_at_max)
                    PC_wrap <= 1'b1;
            end
        end
    end

endmodule
